platform_pool: RTL and testbench
================================

PLATFORM_POOL -- requirements
Module: platform_pool

Interface
REQ-001 Parameter ROWS, default 31: platform rows.
REQ-002 Parameter COLS, default 3: platforms per row; slot count N = ROWS*COLS.
REQ-003 Parameter PLAT_W, default 100: sprite width, px.
REQ-004 Parameter PLAT_H, default 30: sprite height, px.
REQ-005 Parameter ROW_PITCH, default 30: vertical slot spacing, px.
REQ-006 Parameter SCREEN_H, default 768: recycle threshold, px.
REQ-007 Port clk, input, 1: system clock; all logic on rising edge.
REQ-008 Port rst, input, 1: reset, synchronous and active-high.
REQ-009 Port beam_x, input, 11: raster x.
REQ-010 Port beam_y, input, 10: raster y.
REQ-011 Port scroll_valid, input, 1: scroll request.
REQ-012 Port scroll_dy, input, 6: unsigned downward scroll, px.
REQ-013 Port scroll_ready, output, 1: high only in IDLE.
REQ-014 Port platforms, output, N x 2 x 11 signed: [0]=y, [1]=x per slot.
REQ-015 Port platform_activation, output, N: slot enabled.
REQ-016 Port recycled, output, 1: one-cycle pulse per recycled slot.
REQ-017 Port color, output, 3 x 4: RGB pixel.
REQ-018 Port is_transparent, output, 1: pixel alpha.

Function
REQ-019 FSM states IDLE, SHIFT, SWEEP; scroll accepted when scroll_valid && scroll_ready; IDLE->SHIFT, dy latched.
REQ-020 SHIFT: one cycle; every slot y <= y + dy, 11-bit signed; ->SWEEP, index 0.
REQ-021 SWEEP: one slot per cycle, index 0..N-1; slot with y >= SCREEN_H (signed compare) gets y <= y - ROWS*ROW_PITCH, new x, recycled pulsed same cycle; after index N-1 ->IDLE.
REQ-022 Scroll total latency N+1 cycles accept-to-IDLE; scroll_valid outside IDLE ignored, not queued.
REQ-023 dy=0 still runs SHIFT and SWEEP.
REQ-024 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle.
REQ-025 Hit for slot i: x<=beam_x<=x+PLAT_W-1, y<=beam_y<=y+PLAT_H-1, activation set; signed compare, negative y never hits.
REQ-026 Overlapping hits resolved to lowest slot index.
REQ-027 Draw pipeline, 2 cycles: stage 1 registers hit flag and sprite offsets (row, col); stage 2 registers sprite RGB to color and alpha to is_transparent.
REQ-028 No hit: color = 4'hF per channel, is_transparent = 1, at the same 2-cycle latency.
REQ-029 Draw uses positions as updated; tearing during SHIFT/SWEEP accepted.

Reset
REQ-030 rst in any state forces IDLE next cycle; mid-sweep state discarded.
REQ-031 Slot r*COLS+c reset: y = -162 + r*ROW_PITCH, x = 342 + c*114.
REQ-032 platform_activation reset all ones; recycled 0; scroll_ready 1 the first cycle after reset deasserts.
REQ-033 LFSR reset seed 16'hACE1; pipeline registers reset to the no-hit values.

Configuration
REQ-034 Macro PLATFORM_RANDOM_X_EN defined: recycled x = 342 + lfsr[7:0].
REQ-035 Macro undefined: recycled x unchanged; LFSR omitted.

Structure
REQ-036 Shared package platform_pkg holds the FSM state enum, the coordinate typedef (11-bit signed), the LFSR seed and taps, and the constants X_MIN=342, COL_PITCH=114, Y_TOP=-162.
REQ-037 Sub-module platform_sprite_rom: PLAT_H x PLAT_W RGB444 plus alpha, registered read, supplies stage 2.

Verification
REQ-038 After reset, slot 0 = (y -162, x 342), slot 92 = (y 738, x 570); all activation bits 1.
REQ-039 Scroll dy=40 from reset: slot 90 reaches y 778, is recycled to y -152, one recycled pulse for each of slots 90..92; IDLE after 94 cycles.
REQ-040 beam (400, 500) with slot at (x 342, y 498): color equals ROM[2][58] exactly 2 cycles later.
REQ-041 beam outside all slots: color 12'hFFF, is_transparent 1.
REQ-042 scroll_valid held during SWEEP: no second shift occurs; rst asserted mid-SWEEP: reset layout restored next cycle.
REQ-043 Macro on, seed ACE1: recycled x equals 342 + the LFSR value at the recycle cycle; macro off: x unchanged.

Source files
------------

// File: rtl/platform_pkg.sv
// Shared types and constants for the platform pool and its sprite ROM.
package platform_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SWEEP
  } pool_state_t;

  typedef logic signed [10:0] coord_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 (1-based) expressed as a mask over bits 15..0.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int X_MIN     = 342;
  localparam int COL_PITCH = 114;
  localparam int Y_TOP     = -162;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/platform_sprite_rom.sv
// Platform sprite, PLAT_H x PLAT_W RGB444 plus transparency, registered read.
// A miss (or reset) reads back the background: white and transparent.
module platform_sprite_rom #(
  parameter int PLAT_W = 100,
  parameter int PLAT_H = 30,
  parameter int ROW_W  = $clog2(PLAT_H),
  parameter int COL_W  = $clog2(PLAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hit,
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  output logic [2:0][3:0]  o_color,
  output logic             o_transparent
);

  logic [2:0][3:0] w_pixel;
  logic            w_alpha;

  // Contents are a closed-form pattern: red tracks row, green tracks column,
  // blue their sum, and the four 3x3 corners are see-through.
  always_comb begin
    w_pixel    = '0;
    w_pixel[2] = 4'(int'(i_row));
    w_pixel[1] = 4'(int'(i_col));
    w_pixel[0] = 4'(int'(i_row) + int'(i_col));
    w_alpha    = (int'(i_col) < 3 || int'(i_col) >= PLAT_W - 3) &&
                 (int'(i_row) < 3 || int'(i_row) >= PLAT_H - 3);
  end

  always_ff @(posedge clk) begin
    if (rst || !i_hit) begin
      o_color       <= '1;
      o_transparent <= 1'b1;
    end else begin
      o_color       <= w_pixel;
      o_transparent <= w_alpha;
    end
  end

endmodule

// File: rtl/platform_pool.sv
// Scrolling platform slot pool with recycling and a 2-stage sprite draw path.
// Define PLATFORM_RANDOM_X_EN to give recycled platforms an LFSR-derived x.
module platform_pool
  import platform_pkg::*;
#(
  parameter int ROWS      = 31,
  parameter int COLS      = 3,
  parameter int PLAT_W    = 100,
  parameter int PLAT_H    = 30,
  parameter int ROW_PITCH = 30,
  parameter int SCREEN_H  = 768,
  localparam int N        = ROWS * COLS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     beam_x,
  input  logic [9:0]      beam_y,
  input  logic            scroll_valid,
  input  logic [5:0]      scroll_dy,
  output logic            scroll_ready,
  output coord_t          platforms [N][2],
  output logic [N-1:0]    platform_activation,
  output logic            recycled,
  output logic [2:0][3:0] color,
  output logic            is_transparent
);

  localparam int IDX_W = $clog2(N);
  localparam int ROW_W = $clog2(PLAT_H);
  localparam int COL_W = $clog2(PLAT_W);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N - 1);
  localparam coord_t            RECYCLE_DY = coord_t'(ROWS * ROW_PITCH);
  localparam coord_t            SCREEN_Y   = coord_t'(SCREEN_H);
  localparam logic signed [11:0] H_LAST    = 12'(PLAT_H - 1);
  localparam logic signed [11:0] W_LAST    = 12'(PLAT_W - 1);

  pool_state_t       r_state;
  pool_state_t       w_nextState;
  logic              w_accept;
  logic              w_recycle;
  logic [5:0]        r_dy;
  logic [IDX_W-1:0]  r_idx;
  coord_t            r_y [N];
  coord_t            r_x [N];
  logic [N-1:0]      r_act;
  coord_t            w_newX;

  logic signed [11:0] w_bx;
  logic signed [11:0] w_by;
  logic signed [11:0] w_py [N];
  logic signed [11:0] w_px [N];
  logic [N-1:0]       w_slotHit;
  logic               w_hit;
  logic [ROW_W-1:0]   w_row;
  logic [COL_W-1:0]   w_col;
  logic               r_hit1;
  logic [ROW_W-1:0]   r_row1;
  logic [COL_W-1:0]   r_col1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    scroll_ready = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        scroll_ready = 1'b1;
        if (scroll_valid) begin
          w_accept    = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT:   w_nextState = SWEEP;
      SWEEP:   if (r_idx == LAST_IDX) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_recycle = (r_state == SWEEP) && (r_y[r_idx] >= SCREEN_Y);
  assign recycled  = w_recycle;

`ifdef PLATFORM_RANDOM_X_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_newX = coord_t'(X_MIN) + coord_t'({3'b000, r_lfsr[7:0]});
`else
  assign w_newX = r_x[r_idx];
`endif

  // Slot positions: shift everything once, then visit one slot per cycle and
  // wrap any slot that fell off the bottom back above the top row.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_y[r*COLS + c] <= coord_t'(Y_TOP + r * ROW_PITCH);
          r_x[r*COLS + c] <= coord_t'(X_MIN + c * COL_PITCH);
        end
      end
      r_act <= '1;
      r_dy  <= '0;
      r_idx <= '0;
    end else begin
      if (w_accept) begin
        r_dy <= scroll_dy;
      end
      if (r_state == SHIFT) begin
        for (int i = 0; i < N; i++) begin
          r_y[i] <= r_y[i] + coord_t'(r_dy);
        end
        r_idx <= '0;
      end
      if (r_state == SWEEP) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        if (w_recycle) begin
          r_y[r_idx] <= r_y[r_idx] - RECYCLE_DY;
          r_x[r_idx] <= w_newX;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      platforms[i][0] = r_y[i];
      platforms[i][1] = r_x[i];
    end
    platform_activation = r_act;
  end

  assign w_bx = signed'({1'b0, beam_x});
  assign w_by = signed'({2'b00, beam_y});

  // Platforms partly above the screen (negative y) are never drawn.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_py[i]      = r_y[i];
      w_px[i]      = r_x[i];
      w_slotHit[i] = r_act[i] && (w_py[i] >= 12'sd0) &&
                     (w_py[i] <= w_by) && (w_by <= w_py[i] + H_LAST) &&
                     (w_px[i] <= w_bx) && (w_bx <= w_px[i] + W_LAST);
    end
  end

  always_comb begin
    w_hit = 1'b0;
    w_row = '0;
    w_col = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_slotHit[i]) begin
        w_hit = 1'b1;
        w_row = ROW_W'(w_by - w_py[i]);
        w_col = COL_W'(w_bx - w_px[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit1 <= 1'b0;
      r_row1 <= '0;
      r_col1 <= '0;
    end else begin
      r_hit1 <= w_hit;
      r_row1 <= w_row;
      r_col1 <= w_col;
    end
  end

  platform_sprite_rom #(
    .PLAT_W (PLAT_W),
    .PLAT_H (PLAT_H),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_rom (
    .clk           (clk),
    .rst           (rst),
    .i_hit         (r_hit1),
    .i_row         (r_row1),
    .i_col         (r_col1),
    .o_color       (color),
    .o_transparent (is_transparent)
  );

endmodule

// File: tb/tb_platform_pool.sv
// Randomized self-checking bench for platform_pool against a slot-list model.
`timescale 1ns/1ps
module tb_platform_pool;

  localparam int ROWS     = 31;
  localparam int COLS     = 3;
  localparam int N        = ROWS * COLS;
  localparam int PLAT_W   = 100;
  localparam int PLAT_H   = 30;
  localparam int PITCH    = 30;
  localparam int SCREEN_H = 768;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [10:0]              beam_x;
  logic [9:0]               beam_y;
  logic                     scroll_valid;
  logic [5:0]               scroll_dy;
  logic                     scroll_ready;
  logic signed [10:0]       platforms [N][2];
  logic [N-1:0]             platform_activation;
  logic                     recycled;
  logic [2:0][3:0]          color;
  logic                     is_transparent;

  int checks = 0;
  int errors = 0;
  int my [N];
  int mx [N];
  logic [15:0] mLfsr;

  platform_pool dut (
    .clk                 (clk),
    .rst                 (rst),
    .beam_x              (beam_x),
    .beam_y              (beam_y),
    .scroll_valid        (scroll_valid),
    .scroll_dy           (scroll_dy),
    .scroll_ready        (scroll_ready),
    .platforms           (platforms),
    .platform_activation (platform_activation),
    .recycled            (recycled),
    .color               (color),
    .is_transparent      (is_transparent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) mLfsr <= 16'hACE1;
    else     mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int expColor(input int row, input int col);
    return ((row % 16) << 8) | ((col % 16) << 4) | ((row + col) % 16);
  endfunction

  function automatic int expAlpha(input int row, input int col);
    return ((col < 3 || col >= PLAT_W - 3) && (row < 3 || row >= PLAT_H - 3)) ? 1 : 0;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        my[r*COLS + c] = -162 + r * PITCH;
        mx[r*COLS + c] = 342 + c * 114;
      end
  endtask

  task automatic modelPixel(input int bx, input int by, output int ec, output int et);
    ec = 12'hFFF;
    et = 1;
    for (int i = N - 1; i >= 0; i--) begin
      if (my[i] >= 0 && bx >= mx[i] && bx < mx[i] + PLAT_W &&
          by >= my[i] && by < my[i] + PLAT_H) begin
        ec = expColor(by - my[i], bx - mx[i]);
        et = expAlpha(by - my[i], bx - mx[i]);
      end
    end
  endtask

  task automatic checkLayout(input string tag);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s_y%0d", tag, i), int'(platforms[i][0]), my[i]);
      checkOutput($sformatf("%s_x%0d", tag, i), int'(platforms[i][1]), mx[i]);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    scroll_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // scroll_valid stays high until the pool is ready again, so a second
  // shift would show up as a position error.
  task automatic applyScroll(input int dy, output int pulses);
    int n;
    int idx;
    int expPulse;
    bit done;
    pulses = 0;
    @(negedge clk);
    checkOutput("readyBeforeScroll", int'(scroll_ready), 1);
    scroll_valid = 1'b1;
    scroll_dy    = 6'(dy);
    @(posedge clk);
    for (int i = 0; i < N; i++) my[i] += dy;
    @(negedge clk);
    checkOutput("shiftBusy", int'(scroll_ready), 0);
    checkOutput("shiftNoPulse", int'(recycled), 0);
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (scroll_ready) begin
        done = 1'b1;
      end else begin
        idx = n - 1;
        if (idx < N) begin
          expPulse = (my[idx] >= SCREEN_H) ? 1 : 0;
          checkOutput($sformatf("recycled%0d", idx), int'(recycled), expPulse);
          if (recycled) pulses++;
          if (expPulse == 1) begin
            my[idx] -= ROWS * PITCH;
`ifdef PLATFORM_RANDOM_X_EN
            mx[idx] = 342 + int'(mLfsr[7:0]);
`endif
          end
        end
      end
    end
    scroll_valid = 1'b0;
    checkOutput("sweepDone", int'(done), 1);
    checkOutput("scrollLatency", n, N + 1);
    checkLayout("afterScroll");
  endtask

  task automatic applyStimulus(input int count);
    int qc[$];
    int qt[$];
    int bx, by, ec, et, s, i, sel;
    for (int k = 0; k < count + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        ec = qc.pop_front();
        et = qt.pop_front();
        checkOutput("pixelColor", int'(color), ec);
        checkOutput("pixelAlpha", int'(is_transparent), et);
      end
      if (k < count) begin
        s = int'($urandom_range(0, 3));
        if (s == 0) begin
          bx = int'($urandom_range(0, 1200));
          by = int'($urandom_range(0, 800));
        end else begin
          i   = int'($urandom_range(0, N - 1));
          sel = int'($urandom_range(0, 4));
          bx  = mx[i] + ((sel == 0) ? -1 : (sel == 1) ? 0 : (sel == 2) ? PLAT_W - 1 :
                         (sel == 3) ? PLAT_W : int'($urandom_range(0, PLAT_W - 1)));
          sel = int'($urandom_range(0, 4));
          by  = my[i] + ((sel == 0) ? -1 : (sel == 1) ? 0 : (sel == 2) ? PLAT_H - 1 :
                         (sel == 3) ? PLAT_H : int'($urandom_range(0, PLAT_H - 1)));
          if (bx < 0) bx = 0;
          if (by < 0) by = 0;
          if (by > 1023) by = 1023;
        end
        beam_x = 11'(bx);
        beam_y = 10'(by);
        modelPixel(bx, by, ec, et);
        qc.push_back(ec);
        qt.push_back(et);
      end
    end
  endtask

  task automatic applyAbort(input int dy, input int cyclesIn);
    @(negedge clk);
    scroll_valid = 1'b1;
    scroll_dy    = 6'(dy);
    @(posedge clk);
    for (int k = 0; k < cyclesIn; k++) @(posedge clk);
    @(negedge clk);
    checkOutput("midSweepBusy", int'(scroll_ready), 0);
    rst = 1'b1;
    scroll_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("abortReady", int'(scroll_ready), 1);
    checkLayout("abort");
  endtask

  int pulses;

  initial begin
    rst          = 1'b1;
    scroll_valid = 1'b0;
    scroll_dy    = '0;
    beam_x       = '0;
    beam_y       = '0;
    applyReset();
    checkOutput("rstReady", int'(scroll_ready), 1);
    checkOutput("rstRecycled", int'(recycled), 0);
    checkOutput("rstColor", int'(color), 12'hFFF);
    checkOutput("rstAlpha", int'(is_transparent), 1);
    checkOutput("rstActivation", int'(&platform_activation), 1);
    checkOutput("slot0y", int'(platforms[0][0]), -162);
    checkOutput("slot0x", int'(platforms[0][1]), 342);
    checkOutput("slot92y", int'(platforms[92][0]), 738);
    checkOutput("slot92x", int'(platforms[92][1]), 570);
    checkLayout("reset");

    @(negedge clk);
    beam_x = 11'd400;
    beam_y = 10'd500;
    @(negedge clk);
    checkOutput("pixelNotEarly", int'(color), 12'hFFF);
    @(negedge clk);
    checkOutput("pixel2_58", int'(color), expColor(2, 58));
    checkOutput("pixel2_58a", int'(is_transparent), expAlpha(2, 58));
    beam_x = 11'd10;
    beam_y = 10'd5;
    @(negedge clk);
    @(negedge clk);
    checkOutput("missColor", int'(color), 12'hFFF);
    checkOutput("missAlpha", int'(is_transparent), 1);

    applyStimulus(40);

    applyScroll(40, pulses);
    checkOutput("dy40Pulses", pulses, 3);
    checkOutput("slot90y", int'(platforms[90][0]), -152);
    checkOutput("slot89y", int'(platforms[89][0]), 748);

    applyScroll(0, pulses);
    checkOutput("dy0Pulses", pulses, 0);
    applyStimulus(20);

    for (int k = 0; k < 6; k++) begin
      applyScroll(int'($urandom_range(0, 63)), pulses);
      applyStimulus(30);
    end

    applyAbort(50, 30);
    applyStimulus(20);
    applyScroll(63, pulses);
    applyStimulus(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
